// File: rtl/seq_right_shifter.sv
// rtl/seq_right_shifter.sv - multi-cycle right shifter, one bit position per clock
// Logical or arithmetic mode, started/completed with a START/DONE handshake.
module seq_right_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [WIDTH-1:0]   DATA_IN,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic               ARITH,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH-1:0]   DATA_OUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] count_q;
    logic               mode_q;
    logic [WIDTH-1:0]   data_out_q;
    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   shifted;

    assign accept    = START && (state_q == IDLE || state_q == FIN);
    assign last_step = (state_q == SHIFT) && (count_q == SHAMT_W'(1));
    // work_q[MSB] never changes in arithmetic mode, so it stays the latched sign bit
    assign shifted   = {mode_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d = (SHAMT == '0) ? FIN : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (count_q == SHAMT_W'(1)) begin
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == SHIFT);
        DONE = (state_q == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            work_q     <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
        end else if (accept) begin
            work_q  <= DATA_IN;
            count_q <= SHAMT;
            mode_q  <= ARITH;
            if (SHAMT == '0) begin
                data_out_q <= DATA_IN;
            end
        end else if (state_q == SHIFT) begin
            work_q  <= shifted;
            count_q <= count_q - SHAMT_W'(1);
            if (last_step) begin
                data_out_q <= shifted;
            end
        end
    end

    assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// tb/tb_seq_right_shifter.sv - self-checking bench for seq_right_shifter
// Directed and randomized operations against an arithmetic reference model.
module tb_seq_right_shifter;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [15:0] DATA_IN;
    logic [3:0]  SHAMT;
    logic        ARITH;
    logic        BUSY;
    logic        DONE;
    logic [15:0] DATA_OUT;

    int          checks;
    int          passed;
    logic [15:0] last_result;

    seq_right_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA_IN  (DATA_IN),
        .SHAMT    (SHAMT),
        .ARITH    (ARITH),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DATA_OUT (DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s, input logic a);
        if (a) return 16'($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts an operation from the current sample point and returns at the DONE sample.
    task automatic do_op(input logic [15:0] d, input logic [3:0] s, input logic a, input string tag);
        logic [15:0] exp;
        int          lat;
        bit          stable;
        bit          busy_ok;
        exp     = ref_shift(d, int'(s), a);
        START   = 1'b1;
        DATA_IN = d;
        SHAMT   = s;
        ARITH   = a;
        step();
        START   = 1'b0;
        lat     = 1;
        stable  = 1;
        busy_ok = 1;
        while (!DONE && lat < 40) begin
            if (DATA_OUT !== last_result) stable = 0;
            if (BUSY !== 1'b1) busy_ok = 0;
            DATA_IN = 16'($urandom);
            SHAMT   = 4'($urandom);
            ARITH   = 1'($urandom);
            step();
            lat++;
        end
        if (BUSY !== 1'b0) busy_ok = 0;
        checks++;
        if (lat !== int'(s) + 1) $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, int'(s) + 1);
        else passed++;
        checks++;
        if (DATA_OUT !== exp) $display("FAIL %s result: got %h, expected %h", tag, DATA_OUT, exp);
        else passed++;
        checks++;
        if (!stable) $display("FAIL %s data_out_hold: DATA_OUT changed before DONE, expected %h held", tag, last_result);
        else passed++;
        checks++;
        if (!busy_ok) $display("FAIL %s busy: BUSY not high exactly while shifting (shamt %0d)", tag, s);
        else passed++;
        last_result = exp;
    endtask

    task automatic check_done_drops(input string tag);
        step();
        checks++;
        if (DONE !== 1'b0) $display("FAIL %s done_pulse: DONE=%b one cycle later, expected 0", tag, DONE);
        else passed++;
    endtask

    task automatic test_reset();
        bit ok;
        RESET = 1'b1;
        START = 1'b0;
        DATA_IN = 16'hA5A5;
        SHAMT = 4'd3;
        ARITH = 1'b1;
        step();
        step();
        RESET = 1'b0;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (BUSY !== 1'b0 || DONE !== 1'b0 || DATA_OUT !== 16'h0000) ok = 0;
            step();
        end
        checks++;
        if (!ok) $display("FAIL reset_idle: BUSY=%b DONE=%b DATA_OUT=%h, expected 0 0 0000", BUSY, DONE, DATA_OUT);
        else passed++;
        last_result = 16'h0000;
    endtask

    task automatic test_logic_arith();
        do_op(16'h8F00, 4'd4, 1'b0, "lsr_8f00");
        check_done_drops("lsr_8f00");
        do_op(16'h8F00, 4'd4, 1'b1, "asr_8f00");
        check_done_drops("asr_8f00");
    endtask

    task automatic test_boundaries();
        do_op(16'h1234, 4'd0, 1'b0, "shamt0");
        check_done_drops("shamt0");
        do_op(16'h8000, 4'd15, 1'b1, "asr15");
        check_done_drops("asr15");
        do_op(16'h8000, 4'd15, 1'b0, "lsr15");
        check_done_drops("lsr15");
    endtask

    task automatic test_ignored_start();
        int lat;
        int extra;
        START = 1'b1;
        DATA_IN = 16'h8F00;
        SHAMT = 4'd4;
        ARITH = 1'b1;
        step();
        START = 1'b0;
        lat = 1;
        step();
        lat++;
        START = 1'b1;
        DATA_IN = 16'hFFFF;
        SHAMT = 4'd1;
        ARITH = 1'b0;
        step();
        lat++;
        START = 1'b0;
        while (!DONE && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 5) $display("FAIL ignored_start latency: got %0d cycles, expected 5", lat);
        else passed++;
        checks++;
        if (DATA_OUT !== 16'hF8F0) $display("FAIL ignored_start result: got %h, expected f8f0", DATA_OUT);
        else passed++;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (DONE) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL ignored_start extra_done: got %0d DONE pulses, expected 0", extra);
        else passed++;
        last_result = 16'hF8F0;
    endtask

    task automatic test_back_to_back();
        do_op(16'h8F00, 4'd4, 1'b0, "b2b_first");
        do_op(16'h0F0F, 4'd2, 1'b0, "b2b_second");
        checks++;
        if (DATA_OUT !== 16'h03C3) $display("FAIL b2b_value: got %h, expected 03c3", DATA_OUT);
        else passed++;
        check_done_drops("b2b_second");
    endtask

    task automatic test_reset_mid();
        int extra;
        START = 1'b1;
        DATA_IN = 16'hC3A5;
        SHAMT = 4'd10;
        ARITH = 1'b1;
        step();
        START = 1'b0;
        for (int i = 1; i < 4; i++) step();
        checks++;
        if (BUSY !== 1'b1) $display("FAIL reset_mid busy_before: got %b, expected 1", BUSY);
        else passed++;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || DATA_OUT !== 16'h0000)
            $display("FAIL reset_mid state: BUSY=%b DONE=%b DATA_OUT=%h, expected 0 0 0000", BUSY, DONE, DATA_OUT);
        else passed++;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (DONE || BUSY) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL reset_mid activity: got %0d active cycles, expected 0", extra);
        else passed++;
        last_result = 16'h0000;
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [3:0]  s;
        logic        a;
        int          gap;
        for (int n = 0; n < 40; n++) begin
            d = 16'($urandom);
            s = 4'($urandom);
            a = 1'($urandom);
            do_op(d, s, a, "random");
            // Half the time chain straight from FIN, otherwise idle a few cycles.
            gap = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) step();
        end
        step();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        last_result = 16'h0000;
        RESET = 1'b1;
        START = 1'b0;
        DATA_IN = 16'h0000;
        SHAMT = 4'd0;
        ARITH = 1'b0;
        #1;
        test_reset();
        test_logic_arith();
        test_boundaries();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
Multi-cycle 16-bit right shifter. It is the counterpart of the datapath's fixed 1-bit left shifter. It shifts an operand right by a programmable amount of 0..15, one bit position per clock, in either logical (zero-fill) or arithmetic (sign-fill) mode. It sits beside the ALU as a shift-right functional unit and is started and completed by the control unit through a START/DONE handshake.

Parameters:
WIDTH, 16, operand and result width in bits.
SHAMT_W, 4, width of the shift-amount input; max shift = 2^SHAMT_W - 1 = 15.

Ports:
CLK  input  1  single clock; all state changes on rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  request; sampled only when the unit is able to accept it (see Behaviour).
DATA_IN  input  WIDTH  operand; sampled on the accepting edge.
SHAMT  input  SHAMT_W  shift amount; sampled on the accepting edge.
ARITH  input  1  1 = arithmetic shift (fill with operand bit 15); 0 = logical shift (fill with 0); sampled on the accepting edge.
BUSY  output  1  high while a shift is in progress (SHIFT state).
DONE  output  1  one-cycle pulse; high in the cycle DATA_OUT first shows a new result.
DATA_OUT  output  WIDTH  registered result; holds the last completed result.

Behaviour:
- Reset: a synchronous RESET wins over all other inputs. On the reset edge: state=IDLE; working register, count and DATA_OUT = 0; BUSY=0; DONE=0.
- Reset mid-operation aborts the shift. No DONE is produced, and DATA_OUT reads 0 from the next cycle.
- States: IDLE, SHIFT, FIN.
- Accepting START:
  - START is accepted on an edge where state is IDLE or FIN and START=1.
  - On that edge the block latches DATA_IN into the working register, SHAMT into the count, and ARITH into the mode flag.
  - If SHAMT=0, the next state is FIN and DATA_OUT<=DATA_IN on the same edge.
  - If SHAMT≠0, the next state is SHIFT.
- SHIFT:
  - On each edge: work <= {fill, work[15:1]}, where fill = mode ? work[15] : 0; count <= count-1.
  - When count=1 on the edge, DATA_OUT <= the shifted value and the next state is FIN.
  - The sign bit is taken from the latched operand bit 15 and is kept constant throughout the operation.
- FIN:
  - DONE=1 for exactly this one cycle.
  - Next state is IDLE, or a new acceptance if START=1. Back-to-back operations therefore have zero idle cycles.
- Latency: DONE is high SHAMT+1 cycles after the accepting edge (1 cycle for SHAMT=0; 16 cycles for SHAMT=15).
- START while in SHIFT is ignored (not queued). DATA_IN, SHAMT and ARITH changing during SHIFT have no effect.
- BUSY=1 exactly in SHIFT; DONE=1 exactly in FIN. Both are decoded from the state register (no combinational path from inputs).
- DATA_OUT changes only on a completion edge or on reset. It never shows intermediate values.
- Result must equal the combinational reference: ARITH ? $signed(DATA_IN)>>>SHAMT : DATA_IN>>SHAMT.

Test Plan:
- Reset then idle: assert RESET for 2 cycles, then hold START=0 -> BUSY=0, DONE=0, DATA_OUT=0x0000 on every cycle.
- Logical and arithmetic shift of the same operand:
  - DATA_IN=0x8F00, SHAMT=4, ARITH=0 -> DONE pulses 5 cycles after accept, DATA_OUT=0x08F0.
  - Repeat with ARITH=1 -> DATA_OUT=0xF8F0.
- Boundary amounts:
  - SHAMT=0, DATA_IN=0x1234 -> DONE 1 cycle after accept, DATA_OUT=0x1234, BUSY never high.
  - SHAMT=15 on 0x8000, ARITH=1 -> 0xFFFF after 16 cycles.
  - SHAMT=15 on 0x8000, ARITH=0 -> 0x0001.
- Ignored START and input changes: while BUSY, pulse START with DATA_IN=0xFFFF, SHAMT=1 and change ARITH -> original op (0x8F00, SHAMT=4, ARITH=1) completes with 0xF8F0. No extra DONE follows.
- Back-to-back: hold START=1 in the FIN cycle with DATA_IN=0x0F0F, SHAMT=2, ARITH=0 -> next op accepted with no IDLE cycle. DONE pulses again 3 cycles later with DATA_OUT=0x03C3.
- Reset mid-shift: START with SHAMT=10, assert RESET on the 4th SHIFT cycle -> next cycle state IDLE, BUSY=0, DATA_OUT=0. No DONE pulse follows.
